// File: rtl/programmable_sequence_generator.sv
// Serialises a latched pattern MSB-first, repeated N times or continuously until
// stopped.
//   state  | meaning
//   S_IDLE | waiting for start; outputs quiet
//   S_SEND | one pattern bit on dout per cycle
//   S_DONE | single-cycle done pulse, then back to idle
module programmable_sequence_generator #(
  parameter int SEQ_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEQ_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             stop,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(SEQ_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(SEQ_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             stop_pend_q, stop_pend_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // rep_q == 0 marks a continuous run; it is never decremented in that case.
  // A stop arriving in the last bit cycle of a pattern still ends at that boundary.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d = S_SEND;
          pat_d   = pattern;
          rep_d   = repeat_cnt;
          idx_d   = IDX_MSB;
        end
      end
      S_SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (idx_q == '0) begin
          if (rep_q == CNT_W'(1) || stop_pend_q || stop) begin
            state_d = S_DONE;
          end else begin
            idx_d = IDX_MSB;
            if (rep_q != '0) rep_d = rep_q - CNT_W'(1);
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        stop_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    busy        = (state_q == S_SEND);
    dout_valid  = busy;
    dout        = busy ? pat_q[idx_q] : 1'b0;
    frame_start = busy && (idx_q == IDX_MSB);
    done        = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_programmable_sequence_generator.sv
// Directed and randomized runs checked cycle by cycle against a stream-level model.
module tb_programmable_sequence_generator;

  localparam int SEQ_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [SEQ_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic             stop = 1'b0;
  logic             dout, dout_valid, frame_start, busy, done;

  int compared = 0;
  int mismatched = 0;

  programmable_sequence_generator #(.SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .stop(stop), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // {dout, dout_valid, frame_start, busy, done}
  logic [4:0] obs;
  assign obs = {dout, dout_valid, frame_start, busy, done};

  task automatic chk(input string tag, input int k, input logic [4:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Called at a negedge inside an IDLE cycle; returns at a negedge inside an IDLE cycle.
  // stop_at: stream bit index during which stop is raised (-1 none).
  // restart_at: stream bit index during which start is re-pulsed with another pattern.
  task automatic run(input string tag, input logic [SEQ_W-1:0] pat, input logic [CNT_W-1:0] rep,
                     input int stop_at, input int restart_at, input bit stop_with_start,
                     input bit start_in_done);
    int reps;
    int total;
    int pos;
    reps = int'(rep);
    if (stop_at >= 0) begin
      if (rep == 0 || stop_at / SEQ_W + 1 < reps) reps = stop_at / SEQ_W + 1;
    end
    total = reps * SEQ_W;
    start = 1'b1; pattern = pat; repeat_cnt = rep; stop = stop_with_start;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    pattern = SEQ_W'($urandom); repeat_cnt = CNT_W'($urandom);
    for (int k = 0; k < total; k++) begin
      pos = SEQ_W - 1 - (k % SEQ_W);
      chk(tag, k, {pat[pos], 1'b1, (k % SEQ_W) == 0, 1'b1, 1'b0});
      stop = (k == stop_at);
      if (k == restart_at) begin
        start = 1'b1; pattern = ~pat; repeat_cnt = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, total, 5'b00001);
    stop = 1'b1;
    start = start_in_done; pattern = ~pat; repeat_cnt = 8'd2;
    @(negedge clk);
    chk({tag, "_idle"}, total + 1, 5'b00000);
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    logic [SEQ_W-1:0] rp;
    logic [CNT_W-1:0] rr;
    int sa;

    reset = 1'b1; start = 1'b1; pattern = 5'b11111; repeat_cnt = 8'd1;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 0, 5'b00000);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 0, 5'b00000);

    run("single", 5'b10110, 8'd1, -1, -1, 1'b0, 1'b0);
    run("triple", 5'b00111, 8'd3, -1, -1, 1'b0, 1'b0);
    run("cont_stop", 5'b11001, 8'd0, 3 * SEQ_W + 2, -1, 1'b0, 1'b0);
    run("restart_ignored", 5'b10011, 8'd2, -1, 3, 1'b0, 1'b1);
    run("stop_with_start", 5'b01101, 8'd2, -1, -1, 1'b1, 1'b0);
    run("stop_last_bit", 5'b10001, 8'd3, SEQ_W - 1, -1, 1'b0, 1'b0);
    run("cont_stop_first", 5'b01011, 8'd0, 0, -1, 1'b0, 1'b0);

    // Reset during the third bit of a run: no done pulse, then normal restart.
    start = 1'b1; pattern = 5'b10110; repeat_cnt = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("pre_reset_b0", 0, 5'b11110);
    @(negedge clk);
    chk("pre_reset_b1", 1, 5'b01010);
    @(negedge clk);
    chk("pre_reset_b2", 2, 5'b11010);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset", 0, 5'b00000);
    @(negedge clk);
    chk("mid_reset_no_done", 1, 5'b00000);
    run("after_reset", 5'b10110, 8'd1, -1, -1, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      rp = SEQ_W'($urandom);
      rr = CNT_W'($urandom_range(0, 4));
      if (rr == 0) sa = int'($urandom_range(0, 4 * SEQ_W - 1));
      else if ($urandom_range(0, 1) == 1) sa = int'($urandom_range(0, int'(rr) * SEQ_W - 1));
      else sa = -1;
      run("random", rp, rr, sa, int'($urandom_range(0, SEQ_W - 1)), 1'($urandom), 1'($urandom));
    end

    run("long", 5'b11010, 8'd255, -1, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
